// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, int8 limits and the accumulator lane-slice helper.
package npu_pkg;
  localparam int N = 8;
  localparam int ACC_WIDTH = 32;
  localparam int AXI_WIDTH = N * 8;
  localparam int PROD_WIDTH = ACC_WIDTH + 17;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
  function automatic logic [ACC_WIDTH-1:0] acc_slice(input logic [N*ACC_WIDTH-1:0] v, input int j);
    return v[j*ACC_WIDTH +: ACC_WIDTH];
  endfunction
endpackage

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: synchronous FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module npu_sync_fifo #(
  parameter int W = 32,
  parameter int D = 8,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + AW'(1);
  endfunction
  assign do_pop = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(D)) || do_pop);
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_comb begin
    wr_d = clear ? '0 : do_push ? inc(wr_q) : wr_q;
    rd_d = clear ? '0 : do_pop ? inc(rd_q) : rd_q;
    cnt_d = clear ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push && !clear) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/npu_requant_packer.sv
// npu_requant_packer: deskews systolic column outputs, requantizes each lane to
// int8 in a two-stage pipeline and streams packed rows to the DMA.
module npu_requant_packer
  import npu_pkg::*;
#(
  parameter int COL_DEPTH = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [15:0]            cfg_scale,
  input  logic [4:0]             cfg_shift,
  input  logic [7:0]             cfg_zero_point,
  input  logic                   cfg_relu,
  input  logic [N*ACC_WIDTH-1:0] core_y_out,
  input  logic [N-1:0]           core_valid_out,
  output logic [AXI_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   almost_full,
  output logic                   err_overflow,
  output logic [31:0]            rows_out,
  output logic                   busy
);
  localparam int CCW = $clog2(COL_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int PW = PROD_WIDTH;
  localparam int ZW = PW + 1;
  logic [ACC_WIDTH-1:0] col_dout [N];
  logic [CCW-1:0] col_cnt [N];
  logic [N-1:0] col_empty, col_full, col_hi;
  logic [OCW-1:0] out_cnt;
  logic [AXI_WIDTH-1:0] out_dout;
  logic pop, drop;
  logic signed [PW-1:0] s1_p_q [N];
  logic signed [PW-1:0] s1_p_d [N];
  logic signed [PW-1:0] rnd;
  logic [AXI_WIDTH-1:0] s2_word_q, s2_word_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic err_q, err_d, af_q, af_d, busy_q, busy_d;
  logic [31:0] rows_q, rows_d;
  for (genvar j = 0; j < N; j++) begin : g_col
    npu_sync_fifo #(.W(ACC_WIDTH), .D(COL_DEPTH), .CW(CCW)) u_col (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push_i  (core_valid_out[j]),
      .pop_i   (pop),
      .din_i   (acc_slice(core_y_out, j)),
      .dout_o  (col_dout[j]),
      .count_o (col_cnt[j])
    );
    assign col_empty[j] = col_cnt[j] == '0;
    assign col_full[j] = col_cnt[j] == CCW'(COL_DEPTH);
    assign col_hi[j] = col_cnt[j] >= CCW'(COL_DEPTH - 2);
  end
  // Words already in flight reserve output FIFO space so nothing is ever lost downstream.
  assign pop = ~|col_empty && ((int'(out_cnt) + int'(s1_v_q) + int'(s2_v_q)) < OUT_DEPTH);
  assign drop = |(core_valid_out & col_full & ~{N{pop}});
  npu_sync_fifo #(.W(AXI_WIDTH), .D(OUT_DEPTH), .CW(OCW)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push_i  (s2_v_q),
    .pop_i   (out_valid && out_ready),
    .din_i   (s2_word_q),
    .dout_o  (out_dout),
    .count_o (out_cnt)
  );
  always_comb begin
    for (int k = 0; k < N; k++) s1_p_d[k] = PW'($signed(col_dout[k])) * PW'($signed({1'b0, cfg_scale}));
  end
  always_comb begin
    rnd = (cfg_shift == '0) ? '0 : PW'(1) << (cfg_shift - 5'd1);
    s2_word_d = '0;
    for (int k = 0; k < N; k++) begin
      logic signed [PW-1:0] sh, rl;
      logic signed [ZW-1:0] z;
      sh = (s1_p_q[k] + rnd) >>> cfg_shift;
      rl = (cfg_relu && sh[PW-1]) ? '0 : sh;
      z = ZW'(rl) + ZW'($signed(cfg_zero_point));
      s2_word_d[8*k +: 8] = (z > ZW'(INT8_MAX)) ? 8'(INT8_MAX) : (z < ZW'(INT8_MIN)) ? 8'(INT8_MIN) : z[7:0];
    end
  end
  always_comb begin
    s1_v_d = !clear && pop;
    s2_v_d = !clear && s1_v_q;
    err_d = !clear && (err_q || drop);
    rows_d = clear ? '0 : rows_q + 32'(out_valid && out_ready);
    af_d = !clear && |col_hi;
    busy_d = !clear && (~&col_empty || out_valid || s1_v_q || s2_v_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      err_q <= 1'b0;
      rows_q <= '0;
      af_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      err_q <= err_d;
      rows_q <= rows_d;
      af_q <= af_d;
      busy_q <= busy_d;
    end
  always_ff @(posedge clk) begin
    s1_p_q <= s1_p_d;
    s2_word_q <= s2_word_d;
  end
  assign out_valid = out_cnt != '0;
  assign out_data = out_valid ? out_dout : '0;
  assign almost_full = af_q;
  assign err_overflow = err_q;
  assign rows_out = rows_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_npu_requant_packer.sv
// tb_npu_requant_packer: directed plus randomized rows checked against an
// arithmetic requantization model and a queue of expected packed words.
module tb_npu_requant_packer;
  import npu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [15:0] cfg_scale = '0;
  logic [4:0] cfg_shift = '0;
  logic [7:0] cfg_zero_point = '0;
  logic cfg_relu = 1'b0;
  logic [N*ACC_WIDTH-1:0] core_y_out = '0;
  logic [N-1:0] core_valid_out = '0;
  logic [AXI_WIDTH-1:0] out_data;
  logic out_valid, almost_full, err_overflow, busy;
  logic out_ready = 1'b0;
  logic [31:0] rows_out;
  int checks = 0, errors = 0, hs_cnt = 0, used = 0;
  logic [63:0] exp_q [$];
  logic [N*ACC_WIDTH-1:0] row_q [$];
  logic held_v = 1'b0, af_seen = 1'b0;
  logic [63:0] held_d = '0, last_word = '0;

  npu_requant_packer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_zero_point(cfg_zero_point), .cfg_relu(cfg_relu), .core_y_out(core_y_out),
    .core_valid_out(core_valid_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .almost_full(almost_full), .err_overflow(err_overflow),
    .rows_out(rows_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rq(input logic [31:0] acc);
    longint p, d, num, q, r;
    p = longint'($signed(acc)) * longint'(cfg_scale);
    if (cfg_shift == 0) r = p;
    else begin
      d = 64'sd1 << cfg_shift;
      num = p + d / 2;
      q = num / d;
      if (num % d != 0 && num < 0) q = q - 1;
      r = q;
    end
    if (cfg_relu && r < 0) r = 0;
    r = r + longint'($signed(cfg_zero_point));
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic logic [63:0] model_word(input logic [N*ACC_WIDTH-1:0] row);
    logic [63:0] w;
    for (int j = 0; j < N; j++) w[8*j +: 8] = rq(row[32*j +: 32]);
    return w;
  endfunction

  function automatic logic [N*ACC_WIDTH-1:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic gen_rows(input int n);
    logic [N*ACC_WIDTH-1:0] row;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < N; j++) row[32*j +: 32] = int'($urandom) >>> $urandom_range(0, 31);
      row_q.push_back(row);
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*ACC_WIDTH-1:0] d, input logic rdy);
    @(negedge clk);
    if (held_v) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, held_d);
    end
    core_valid_out = v;
    core_y_out = d;
    out_ready = rdy;
    af_seen = af_seen | almost_full;
    if (out_valid && rdy) begin
      chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("word_data", out_data, exp_q.pop_front());
      last_word = out_data;
      hs_cnt++;
    end
    held_v = out_valid && !rdy;
    held_d = out_data;
  endtask

  task automatic send_rows(input int n, input int period, input int rmode, input int keep);
    logic [N*ACC_WIDTH-1:0] rows [$];
    logic [N-1:0] v;
    logic [N*ACC_WIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      rows.push_back(row_q.pop_front());
      if (k < keep) exp_q.push_back(model_word(rows[k]));
    end
    for (int t = 0; t < period * (n - 1) + N; t++) begin
      v = '0;
      d = '0;
      for (int j = 0; j < N; j++)
        if (t >= j && (t - j) % period == 0 && (t - j) / period < n) begin
          v[j] = 1'b1;
          d[32*j +: 32] = rows[(t - j) / period][32*j +: 32];
        end
      cycle(v, d, rmode == 2 ? ($urandom_range(0, 3) != 0) : rmode == 1);
    end
  endtask

  task automatic drain(input int bound, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle('0, '0, 1'b1);
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cycle('0, '0, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle('0, '0, rdy);
  endtask

  task automatic pulse_clear();
    held_v = 1'b0;
    clear = 1'b1;
    cycle('0, '0, 1'b0);
    clear = 1'b0;
    hs_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_almost_full", 64'(almost_full), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    chk("rst_rows_out", 64'(rows_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cfg_scale = 16'd1;
    // Saturation, packing and three-edge latency after the last column.
    row_q.push_back(pack8(0, 1, -1, 127, 128, -129, 1000, -1000));
    send_rows(1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle('0, '0, 1'b0);
      chk("latency_low", 64'(out_valid), 64'd0);
    end
    cycle('0, '0, 1'b0);
    chk("latency_high", 64'(out_valid), 64'd1);
    chk("sat_word", out_data, 64'h807F807F7FFF0100);
    drain(10, used);
    // Rounding with zero-point.
    cfg_scale = 16'd3; cfg_shift = 5'd2; cfg_zero_point = 8'd10;
    row_q.push_back(pack8(5, -5, 0, 7, -7, 100, -100, 3));
    send_rows(1, 1, 1, 1);
    drain(10, used);
    chk("round_pos", 64'(last_word[7:0]), 64'd14);
    chk("round_neg", 64'(last_word[15:8]), 64'd6);
    // ReLU.
    cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_relu = 1'b1;
    row_q.push_back(pack8(-50, 40, -1, 0, 200, -200, 117, 118));
    send_rows(1, 1, 1, 1);
    drain(10, used);
    chk("relu_neg", 64'(last_word[7:0]), 64'd10);
    chk("relu_pos", 64'(last_word[15:8]), 64'd50);
    // Sustained one row per cycle.
    cfg_scale = 16'd777; cfg_shift = 5'd9; cfg_zero_point = 8'hF0; cfg_relu = 1'b0;
    gen_rows(20);
    send_rows(20, 1, 1, 20);
    drain(20, used);
    chk("throughput_tail", 64'(used), 64'd4);
    idle(3, 1'b1);
    chk("rows_after_tput", 64'(rows_out), 64'(hs_cnt));
    // Backpressure: 4 words queue, 2 rows wait in the columns.
    pulse_clear();
    af_seen = 1'b0;
    gen_rows(6);
    send_rows(6, 2, 0, 6);
    idle(6, 1'b0);
    chk("bp_out_cnt", 64'(dut.out_cnt), 64'd4);
    chk("bp_col0_cnt", 64'(dut.col_cnt[0]), 64'd2);
    chk("bp_col7_cnt", 64'(dut.col_cnt[7]), 64'd2);
    chk("bp_af_seen", 64'(af_seen), 64'd0);
    chk("bp_err", 64'(err_overflow), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    drain(30, used);
    cycle('0, '0, 1'b0);
    chk("bp_rows_out", 64'(rows_out), 64'd6);
    // Overflow: the 13th row is dropped in every column.
    gen_rows(13);
    send_rows(13, 1, 0, 12);
    idle(4, 1'b0);
    chk("ovf_err", 64'(err_overflow), 64'd1);
    chk("ovf_af", 64'(almost_full), 64'd1);
    drain(40, used);
    idle(4, 1'b1);
    chk("ovf_rows_out", 64'(rows_out), 64'(hs_cnt));
    chk("ovf_busy_idle", 64'(busy), 64'd0);
    chk("ovf_err_held", 64'(err_overflow), 64'd1);
    pulse_clear();
    chk("clr_err", 64'(err_overflow), 64'd0);
    chk("clr_rows_out", 64'(rows_out), 64'd0);
    chk("clr_af", 64'(almost_full), 64'd0);
    // Randomized configurations with random backpressure.
    for (int c = 0; c < 4; c++) begin
      cfg_scale = 16'($urandom);
      cfg_shift = 5'($urandom_range(0, 31));
      cfg_zero_point = 8'($urandom);
      cfg_relu = 1'($urandom_range(0, 1));
      gen_rows(10);
      send_rows(10, $urandom_range(1, 2), 2, 10);
      drain(60, used);
      idle(3, 1'b1);
      chk("rand_rows_out", 64'(rows_out), 64'(hs_cnt));
      chk("rand_busy", 64'(busy), 64'd0);
    end
    // Reset mid-stream with two words queued.
    gen_rows(3);
    send_rows(2, 1, 0, 2);
    idle(4, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rows", 64'(rows_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    exp_q.delete();
    held_v = 1'b0;
    hs_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_rows(1, 1, 1, 1);
    drain(20, used);
    idle(2, 1'b1);
    chk("post_rst_rows", 64'(rows_out), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_requant_packer.md
# npu_requant_packer

Output stage sitting directly downstream of the 8x8 systolic core and upstream of the DMA write stream. It deskews the per-column 32-bit accumulator outputs, requantizes each lane to int8 (scale, rounding shift, ReLU, zero-point, saturation), and packs one row into a 64-bit word. Packed words are buffered and delivered over a valid/ready stream to the DMA. The core cannot be stalled, so the block exports an early-warning flag to the sequencer and latches a sticky overflow error.

## Interface
- `N`, 8, columns/lanes per row
- `ACC_WIDTH`, 32, signed accumulator width per column
- `AXI_WIDTH`, 64, packed output width (= N*8)
- `COL_DEPTH`, 8, per-column deskew FIFO depth
- `OUT_DEPTH`, 4, packed-word output FIFO depth

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `clear` in 1: synchronous flush of all FIFOs, pipeline, counters and error flag
- `cfg_scale` in 16: unsigned multiplier
- `cfg_shift` in 5: arithmetic right shift, 0..31
- `cfg_zero_point` in 8: signed output offset
- `cfg_relu` in 1: clamp negative pre-offset values to 0
- `core_y_out` in N*ACC_WIDTH: column j at bits [32j+31:32j]
- `core_valid_out` in N: per-column valid, skewed (column j arrives j cycles after column 0)
- `out_data` out AXI_WIDTH: lane j at bits [8j+7:8j]
- `out_valid` out 1, `out_ready` in 1: DMA-side stream handshake
- `almost_full` out 1: any column FIFO holds >= COL_DEPTH-2 entries
- `err_overflow` out 1: sticky; a column push was dropped
- `rows_out` out 32: count of words accepted by the DMA
- `busy` out 1: any FIFO or pipeline stage non-empty

## Operation
- Each column has its own FIFO. Column j pushes `core_y_out[j]` whenever `core_valid_out[j]`=1.
- Pushing a full column FIFO drops that entry and sets `err_overflow`. Other columns are unaffected.
- Pop happens in the same cycle from all N FIFOs when all of these hold:
  - every column FIFO is non-empty;
  - output FIFO count + in-flight stages < OUT_DEPTH.
- Stage S1 (registered): p = acc (signed 32) * scale (zero-extended) gives a signed 49-bit product.
- Stage S2 (registered):
  - r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, an arithmetic shift;
  - if relu and r<0, then r=0;
  - r = r + sign-extended zero_point;
  - saturate r to [-128,127];
  - pack into the lane and write to the output FIFO.
- Column order and row order are preserved. No reordering.
- `rows_out` increments on each `out_valid && out_ready`. It wraps at 2^32.
- `cfg_*` must be static while `busy`=1. A mid-row change is undefined.
- `clear` and `rst_n` have identical effect. `clear` takes priority over a same-cycle push or pop.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `almost_full`=0, `err_overflow`=0, `rows_out`=0, `busy`=0.
- Latency: column N-1 valid sampled at edge t, with the output FIFO empty and no backpressure, gives `out_valid`=1 after edge t+3.
- Throughput: one row per cycle sustained with `out_ready`=1.
- `out_data` is held stable while `out_valid && !out_ready`.
- `out_valid` never deasserts without a handshake.
- Simultaneous push and pop on a full column FIFO is accepted, with no overflow.
- Simultaneous write and read on a full output FIFO is accepted.
- `almost_full` and `busy` are registered flags.

## Structure
- Shared package `npu_pkg` holds:
  - N, ACC_WIDTH, AXI_WIDTH;
  - INT8_MIN=-128 and INT8_MAX=127;
  - the lane-slice helper function.
- Sub-module `npu_sync_fifo` (parameterised width/depth, count output) is instantiated N times for the columns and once for the packed words.
- The requant arithmetic stays inline.

## Test plan
- **Saturation and packing.** scale=1, shift=0, zp=0, relu=0. Skewed row [0,1,-1,127,128,-129,1000,-1000] gives `out_data`=0x807F807F7FFF0100, 3 cycles after column 7 valid.
- **Rounding and zero-point.** scale=3, shift=2, zp=10. acc 5 gives lane 14; acc -5 gives lane 6.
- **ReLU.** relu=1, zp=10. acc -50 gives 10; acc 40 (scale=1, shift=0) gives 50.
- **Backpressure.** `out_ready`=0 while 6 rows are pushed:
  - 4 words are queued and 2 rows stay in the column FIFOs;
  - `almost_full` stays 0 and `err_overflow` stays 0;
  - releasing `out_ready` yields 6 words in order and `rows_out`=6.
- **Overflow.** `out_ready`=0 while 13 rows are pushed. `err_overflow`=1, the 13th row is dropped, and 12 words drain. `clear` then zeroes the flag.
- **Reset mid-stream.** `rst_n` pulsed low with 2 words queued:
  - `out_valid`=0 and `rows_out`=0 immediately;
  - `busy`=0;
  - the next row processes normally.
